// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: per-requester credits reloaded from weight, grant held until done.
// Optional starvation promotion is compiled in when WRR_STARVE_EN is defined.
module wrr_arbiter #(
   parameter int NREQ         = 4,
   parameter int WW           = 8,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic                    done,
   input  logic [NREQ*WW-1:0]      weight,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_id,
   output logic                    gnt_vld,
   output logic [NREQ-1:0]         starved
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, RELOAD, GRANT} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   credit_q [NREQ];
   logic [WW-1:0]   credit_d [NREQ];
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   gnt_id_q, gnt_id_d;
   logic            gnt_vld_q, gnt_vld_d;
   logic            prio_q, prio_d;

   logic [NREQ-1:0] weight_nz, credit_nz, eligible, starve_vec;
   logic            pick_vld, pick_prio;
   logic [IW-1:0]   pick_id;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_nz
         assign weight_nz[gi] = (weight[gi*WW +: WW] != '0);
         assign credit_nz[gi] = (credit_q[gi] != '0);
      end
   endgenerate

   // In RELOAD the fresh weights become the credits, so arbitrate on them directly.
   assign eligible = req & ((state_q == RELOAD) ? weight_nz : credit_nz);

   always_comb begin
      int idx;
      idx       = 0;
      pick_vld  = 1'b0;
      pick_prio = 1'b0;
      pick_id   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!pick_vld && eligible[idx]) begin
            pick_vld = 1'b1;
            pick_id  = IW'(idx);
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (starve_vec[i]) begin
            pick_vld  = 1'b1;
            pick_prio = 1'b1;
            pick_id   = IW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= IW'(NREQ - 1);
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         gnt_vld_q <= 1'b0;
         prio_q    <= 1'b0;
         for (int i = 0; i < NREQ; i++) credit_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
         prio_q    <= prio_d;
         credit_q  <= credit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_vld)
               state_d = GRANT;
            else if ((req & weight_nz) != '0)
               state_d = RELOAD;
         end
         RELOAD:  state_d = pick_vld ? GRANT : IDLE;
         GRANT:   if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_vld_d = gnt_vld_q;
      ptr_d     = ptr_q;
      prio_d    = prio_q;
      credit_d  = credit_q;
      if (state_q == RELOAD) begin
         for (int i = 0; i < NREQ; i++) credit_d[i] = weight[i*WW +: WW];
      end
      if ((state_q == IDLE || state_q == RELOAD) && pick_vld) begin
         gnt_d     = NREQ'(1) << pick_id;
         gnt_id_d  = pick_id;
         gnt_vld_d = 1'b1;
         prio_d    = pick_prio;
      end
      if (state_q == GRANT && done) begin
         gnt_d     = '0;
         gnt_vld_d = 1'b0;
         ptr_d     = gnt_id_q;
         // A starvation-promoted grant is free; credits never wrap below zero.
         if (!prio_q && credit_q[gnt_id_q] != '0)
            credit_d[gnt_id_q] = credit_q[gnt_id_q] - WW'(1);
      end
   end

`ifdef WRR_STARVE_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_starve
         logic [CW-1:0] wait_q, wait_d;
         always_comb begin
            wait_d = wait_q;
            if (!req[gi] || gnt_q[gi])
               wait_d = '0;
            else if (wait_q != CW'(STARVE_LIMIT))
               wait_d = wait_q + CW'(1);
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) wait_q <= '0;
            else        wait_q <= wait_d;
         end
         assign starve_vec[gi] = (wait_q == CW'(STARVE_LIMIT));
      end
   endgenerate
`else
   assign starve_vec = '0;
`endif

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = gnt_vld_q;
   assign starved = starve_vec;

endmodule
